// File: rtl/load_align_queue.sv
// load_align_queue: aligns/extends load responses and queues them in order.
// Define LOAD_ALIGN_EXC_EN to flag misaligned accesses via out_exc.
module load_align_queue #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int TAG_W  = 5,
  localparam int OFF_W = $clog2(DATA_W/8),
  localparam int CNT_W = $clog2(DEPTH)+1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [OFF_W-1:0]  in_off,
  input  logic [DATA_W-1:0] in_data,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_exc,
  output logic [CNT_W-1:0]  count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  localparam logic [2:0] OP_LB  = 3'd0;
  localparam logic [2:0] OP_LBU = 3'd1;
  localparam logic [2:0] OP_LH  = 3'd2;
  localparam logic [2:0] OP_LHU = 3'd3;
  localparam logic [2:0] OP_LW  = 3'd4;
  localparam logic [2:0] OP_LWU = 3'd5;
`ifdef LOAD_ALIGN_EXC_EN
  localparam logic [2:0] OP_LD  = 3'd6;
`endif

  logic [DATA_W-1:0] data_q [DEPTH];
  logic [TAG_W-1:0]  tag_q  [DEPTH];
  logic              exc_q  [DEPTH];

  logic [PW-1:0]    wr_q, wr_d;
  logic [PW-1:0]    rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic push, pop;

  logic              is_b, is_h, is_w, sgn, mis;
  logic [OFF_W-1:0]  aoff;
  logic [DATA_W-1:0] sh;
  logic [DATA_W-1:0] ext;
  logic [DATA_W-1:0] st_data;

  assign in_ready  = cnt_q < FULL;
  assign out_valid = cnt_q != '0;
  assign count     = cnt_q;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  assign is_b = (in_op == OP_LB) | (in_op == OP_LBU);
  assign is_h = (in_op == OP_LH) | (in_op == OP_LHU);
  assign is_w = (in_op == OP_LW) | (in_op == OP_LWU);
  assign sgn  = ~in_op[0];

  // Pick the aligned lane, shift it down and extend to full width.
  always_comb begin
    aoff = '0;
    ext  = '0;
    unique case (1'b1)
      is_b: aoff = in_off;
      is_h: aoff = in_off & ~OFF_W'(1);
      is_w: aoff = in_off & ~OFF_W'(3);
      default: aoff = '0;
    endcase
    sh = in_data >> {aoff, 3'b000};
    unique case (1'b1)
      is_b: ext = sgn ? DATA_W'($signed(sh[7:0]))
                      : DATA_W'(sh[7:0]);
      is_h: ext = sgn ? DATA_W'($signed(sh[15:0]))
                      : DATA_W'(sh[15:0]);
      is_w: ext = sgn ? DATA_W'($signed(sh[31:0]))
                      : DATA_W'(sh[31:0]);
      default: ext = sh;
    endcase
  end

  // Misalignment flag; a faulting entry carries zero data.
  always_comb begin
`ifdef LOAD_ALIGN_EXC_EN
    mis = (is_h & in_off[0])
        | (is_w & (|in_off[1:0]))
        | ((in_op == OP_LD) & (|in_off));
`else
    mis = 1'b0;
`endif
    st_data = mis ? '0 : ext;
  end

  // Pointer and occupancy next state; flush wins over push/pop.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) wr_d = wr_q + 1'b1;
      if (pop)  rd_d = rd_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry storage, written on an accepted push.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      data_q[wr_q] <= st_data;
      tag_q[wr_q]  <= in_tag;
      exc_q[wr_q]  <= mis;
    end
  end

  assign out_data = out_valid ? data_q[rd_q] : '0;
  assign out_tag  = out_valid ? tag_q[rd_q]  : '0;
  assign out_exc  = out_valid ? exc_q[rd_q]  : 1'b0;

endmodule

// File: tb/tb_load_align_queue.sv
// tb_load_align_queue: directed and random checks of load_align_queue
// against a queue-based reference model (DATA_W=32, DEPTH=4).
module tb_load_align_queue;

  localparam int DW = 32;
  localparam int DEPTH = 4;
  localparam int TW = 5;
  localparam int OW = 2;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    in_op;
  logic [OW-1:0] in_off;
  logic [DW-1:0] in_data;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [TW-1:0] out_tag;
  logic          out_exc;
  logic [CW-1:0] count;

  load_align_queue #(
    .DATA_W(DW),
    .DEPTH(DEPTH),
    .TAG_W(TW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_op(in_op),
    .in_off(in_off),
    .in_data(in_data),
    .in_tag(in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_tag(out_tag),
    .out_exc(out_exc),
    .count(count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d;
    logic [4:0]  t;
    logic        e;
  } ent_t;

  ent_t mq[$];
  int checks = 0;
  int errors = 0;

  task automatic check(string name, logic [63:0] obs, logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, expv);
    end
  endtask

  function automatic ent_t ref_ent(logic [2:0] op, logic [1:0] off,
                                   logic [31:0] d, logic [4:0] t);
    ent_t r;
    logic [7:0] b;
    logic [15:0] h;
    b = d[8*int'(off) +: 8];
    h = d[16*int'(off[1]) +: 16];
    r.t = t;
    r.e = 1'b0;
    case (op)
      3'd0: r.d = {{24{b[7]}}, b};
      3'd1: r.d = {24'b0, b};
      3'd2: r.d = {{16{h[15]}}, h};
      3'd3: r.d = {16'b0, h};
      default: r.d = d;
    endcase
`ifdef LOAD_ALIGN_EXC_EN
    if (((op == 3'd2 || op == 3'd3) && off[0]) ||
        ((op == 3'd4 || op == 3'd5) && off != 2'd0) ||
        (op == 3'd6 && off != 2'd0)) begin
      r.e = 1'b1;
      r.d = '0;
    end
`endif
    return r;
  endfunction

  task automatic check_out(string n);
    check({n, ".count"}, 64'(count), 64'(mq.size()));
    check({n, ".out_valid"}, 64'(out_valid), 64'(mq.size() != 0));
    check({n, ".in_ready"}, 64'(in_ready), 64'(mq.size() < DEPTH));
    if (mq.size() != 0) begin
      check({n, ".data"}, 64'(out_data), 64'(mq[0].d));
      check({n, ".tag"}, 64'(out_tag), 64'(mq[0].t));
      check({n, ".exc"}, 64'(out_exc), 64'(mq[0].e));
    end else begin
      check({n, ".data0"}, 64'(out_data), 64'd0);
      check({n, ".tag0"}, 64'(out_tag), 64'd0);
      check({n, ".exc0"}, 64'(out_exc), 64'd0);
    end
  endtask

  task automatic drive(logic v, logic [2:0] op, logic [1:0] off,
                       logic [31:0] d, logic [4:0] t, logic rdy);
    in_valid  = v;
    in_op     = op;
    in_off    = off;
    in_data   = d;
    in_tag    = t;
    out_ready = rdy;
  endtask

  task automatic step(string n);
    logic push, pop;
    push = in_valid && (mq.size() < DEPTH);
    pop  = (mq.size() != 0) && out_ready;
    @(posedge clk);
    if (flush) mq.delete();
    else begin
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back(ref_ent(in_op, in_off, in_data, in_tag));
    end
    #1;
    check_out(n);
  endtask

  task automatic drain();
    drive(1'b0, 3'd7, 2'd0, 32'd0, 5'd0, 1'b1);
    for (int i = 0; i < DEPTH + 1; i++) step("drain");
  endtask

  initial begin
    reset = 1'b0;
    flush = 1'b0;
    drive(1'b0, 3'd0, 2'd0, 32'd0, 5'd0, 1'b0);
    #12;
    check_out("reset");
    reset = 1'b1;

    // Sign-extended byte from the top lane.
    drive(1'b1, 3'd0, 2'd3, 32'h80FF_1234, 5'h0A, 1'b0);
    step("lb");
    check("lb.const", 64'(out_data), 64'h0000_0000_FFFF_FF80);
    check("lb.tag", 64'(out_tag), 64'h0A);
    drain();

    // Upper halfword, unsigned then signed.
    drive(1'b1, 3'd3, 2'd2, 32'h8001_7FFF, 5'h11, 1'b0);
    step("lhu");
    drive(1'b1, 3'd2, 2'd2, 32'h8001_7FFF, 5'h12, 1'b0);
    step("lh");
    check("lhu.const", 64'(out_data), 64'h0000_8001);
    drive(1'b0, 3'd0, 2'd0, 32'd0, 5'd0, 1'b1);
    step("lhu.pop");
    check("lh.const", 64'(out_data), 64'hFFFF_8001);
    drain();

    // Fill to full with the consumer stalled; fifth offer held.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 3'd7, 2'd0, 32'h100 + i, 5'(i), 1'b0);
      step("fill");
    end
    check("full.count", 64'(count), 64'd4);
    check("full.in_ready", 64'(in_ready), 64'd0);
    drive(1'b0, 3'd7, 2'd0, 32'd0, 5'd0, 1'b1);
    step("pop1");
    check("pop1.in_ready", 64'(in_ready), 64'd1);
    check("pop1.head", 64'(out_data), 64'h101);
    for (int i = 0; i < 3; i++) step("drainfull");

    // Steady push+pop at count 2 across pointer wrap.
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 3'd7, 2'd0, 32'h200 + i, 5'(i), 1'b0);
      step("pre2");
    end
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 3'd1, 2'(i), 32'($urandom), 5'(i + 2), 1'b1);
      step("pp");
      check("pp.count", 64'(count), 64'd2);
    end
    drain();

    // Misaligned word access.
    drive(1'b1, 3'd4, 2'd2, 32'hDEAD_BEEF, 5'h1F, 1'b0);
    step("lw_mis");
`ifdef LOAD_ALIGN_EXC_EN
    check("lw_mis.exc", 64'(out_exc), 64'd1);
    check("lw_mis.data", 64'(out_data), 64'd0);
`else
    check("lw_mis.exc", 64'(out_exc), 64'd0);
    check("lw_mis.data", 64'(out_data), 64'hDEAD_BEEF);
`endif
    drain();

    // Random traffic with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 9) < 7), 3'($urandom), 2'($urandom),
            32'($urandom), 5'($urandom), 1'($urandom));
      flush = ($urandom_range(0, 19) == 0);
      step("rand");
    end
    flush = 1'b0;
    drain();

    // Flush beats a same-cycle push.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 3'd7, 2'd0, 32'h300 + i, 5'(i), 1'b0);
      step("pre3");
    end
    check("pre3.count", 64'(count), 64'd3);
    drive(1'b1, 3'd7, 2'd0, 32'h3FF, 5'h3, 1'b0);
    flush = 1'b1;
    step("flush");
    flush = 1'b0;
    check("flush.count", 64'(count), 64'd0);
    check("flush.out_valid", 64'(out_valid), 64'd0);

    // Asynchronous reset mid-cycle, then a fresh push.
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 3'd7, 2'd0, 32'h400 + i, 5'(i), 1'b0);
      step("pre_rst");
    end
    drive(1'b0, 3'd0, 2'd0, 32'd0, 5'd0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    mq.delete();
    check("arst.count", 64'(count), 64'd0);
    check("arst.out_valid", 64'(out_valid), 64'd0);
    check("arst.in_ready", 64'(in_ready), 64'd1);
    #1;
    reset = 1'b1;
    drive(1'b1, 3'd2, 2'd1, 32'h1234_F678, 5'h07, 1'b0);
    step("post_rst");
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/load_align_queue.md
LOAD_ALIGN_QUEUE -- requirements
Module: load_align_queue

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, memory word width (32 or 64 only).
REQ-002 The block SHALL have parameter DEPTH, default 4, result-queue entries (power of two, 2..16).
REQ-003 The block SHALL have parameter TAG_W, default 5, destination-register tag width.
REQ-004 Derived widths SHALL be OFF_W = log2(DATA_W/8) and CNT_W = log2(DEPTH)+1.
REQ-005 The block SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-006 The block SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-007 The block SHALL have port flush  input  1  synchronous queue clear.
REQ-008 The block SHALL have port in_valid  input  1  load response present.
REQ-009 The block SHALL have port in_ready  output  1  queue can accept.
REQ-010 The block SHALL have port in_op  input  3  0 LB, 1 LBU, 2 LH, 3 LHU, 4 LW, 5 LWU, 6 LD, 7 raw.
REQ-011 The block SHALL have port in_off  input  OFF_W  byte offset of access within word.
REQ-012 The block SHALL have port in_data  input  DATA_W  raw memory word.
REQ-013 The block SHALL have port in_tag  input  TAG_W  destination tag, carried unchanged.
REQ-014 The block SHALL have port out_valid  output  1  queue head valid.
REQ-015 The block SHALL have port out_ready  input  1  consumer accepts head.
REQ-016 The block SHALL have ports out_data  output  DATA_W, out_tag  output  TAG_W, out_exc  output  1  (head entry fields).
REQ-017 The block SHALL have port count  output  CNT_W  number of occupied entries.

Function
REQ-018 Push SHALL occur on a rising edge where in_valid and in_ready are both 1; pop SHALL occur where out_valid and out_ready are both 1.
REQ-019 in_ready SHALL equal (count < DEPTH), derived from registered count only; no same-cycle pass-through when full, even with a simultaneous pop.
REQ-020 out_valid SHALL equal (count != 0); an entry pushed at edge N SHALL be visible at the head after edge N (latency 1 cycle when the queue was empty).
REQ-021 Extension SHALL be computed combinationally from in_op/in_off/in_data before the push edge and stored; out_* SHALL be driven from the stored head entry.
REQ-022 Byte ops SHALL select byte in_off, halfword ops halfword in_off[OFF_W-1:1], word ops word in_off[OFF_W-1:2] (64-bit only); signed ops sign-extend to DATA_W, unsigned ops zero-extend.
REQ-023 With DATA_W=32, LWU, LD and raw SHALL return in_data unchanged; with DATA_W=64, LD and raw SHALL return in_data unchanged.
REQ-024 Simultaneous push and pop SHALL leave count unchanged and preserve FIFO order.
REQ-025 Read/write pointers SHALL wrap modulo DEPTH with no lost or duplicated entry.
REQ-026 flush SHALL take priority over push and pop: count becomes 0 at that edge, any same-cycle push is discarded, out_valid is 0 the following cycle.
REQ-027 Pop on an empty queue and push on a full queue SHALL be impossible by construction (ready/valid gating); state SHALL not change.

Reset
REQ-028 reset low SHALL immediately clear pointers and count: count=0, out_valid=0, in_ready=1, out_exc=0, out_data=0, out_tag=0.
REQ-029 Reset asserted mid-stream SHALL discard all entries; the first push after release SHALL appear at the head as if the queue were new.

Configuration
REQ-030 Macro LOAD_ALIGN_EXC_EN SHALL control misalignment detection.
REQ-031 With LOAD_ALIGN_EXC_EN defined, a halfword op with in_off[0]=1, word op with in_off[1:0]!=0, or LD with in_off!=0 SHALL store out_exc=1 and out_data=0 for that entry.
REQ-032 Without LOAD_ALIGN_EXC_EN, out_exc SHALL be constant 0 and misaligned offsets SHALL be truncated to the natural alignment (low bits ignored).

Verification
REQ-033 DATA_W=32: push LB off=3 data=0x80FF_1234 -> next cycle out_valid=1, out_data=0xFFFF_FF80, tag preserved.
REQ-034 DATA_W=32: push LHU off=2 data=0x8001_7FFF -> out_data=0x0000_8001; LH same -> 0xFFFF_8001.
REQ-035 DEPTH=4, out_ready=0, 5 pushes offered -> count=4, in_ready=0, 5th held; then out_ready=1 drains 4 entries in order, in_ready returns 1 after first pop.
REQ-036 Queue count=2, push+pop same edge -> count stays 2, order correct across pointer wrap over 10 such cycles.
REQ-037 With LOAD_ALIGN_EXC_EN, LW off=2 -> out_exc=1, out_data=0; without macro -> out_exc=0, out_data=in_data.
REQ-038 count=3, flush=1 with in_valid=1 -> next cycle count=0, out_valid=0; reset low async mid-cycle -> count=0 before next edge.
